unpacker: RTL and testbench

Serializes wide words read from the word FIFO into a stream of DATA_WIDTH-bit bytes written into the byte (UART TX side) FIFO. It is the read-back counterpart of the byte-to-word packer: it consumes WORD_WIDTH-bit words returned from DDR over AXI. It emits bytes least-significant first, so a word built by the packer is reproduced in its original byte order.

---
 rtl/unpacker.sv | 100 ++++++++++
 tb/tb_unpacker.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/unpacker.sv
// Word-to-byte serializer: pops wide words from the word FIFO and emits them LSB byte first.
// Optional build macro UNPACKER_PREFETCH_EN overlaps the next word fetch with the last byte.
module unpacker #(
  parameter int DATA_WIDTH = 8,
  parameter int WORD_WIDTH = 256
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [WORD_WIDTH-1:0] word_in,
  input  logic                  word_fifo_empty,
  output logic                  word_read_enable,
  input  logic                  byte_fifo_full,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  write_enable,
  output logic                  busy
);

  localparam int BYTES = WORD_WIDTH / DATA_WIDTH;
  localparam int CNT_W = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BYTES - 1);

  typedef enum logic [1:0] {IDLE, LOAD, SEND} state_t;

  state_t                state_q, state_d;
  logic [WORD_WIDTH-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  last_byte;

  assign last_byte = (count_q == LAST);
  assign data_out  = shift_q[DATA_WIDTH-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      shift_q <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    count_d = count_q;
    case (state_q)
      IDLE: begin
        if (word_read_enable) state_d = LOAD;
      end
      LOAD: begin
        shift_d = word_in;
        count_d = '0;
        state_d = SEND;
      end
      SEND: begin
        // A full byte FIFO freezes everything, so data_out holds through the stall.
        if (write_enable) begin
          shift_d = shift_q >> DATA_WIDTH;
          if (last_byte) begin
            count_d = '0;
            state_d = word_read_enable ? LOAD : IDLE;
          end else begin
            count_d = count_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    write_enable     = 1'b0;
    word_read_enable = 1'b0;
    busy             = 1'b0;
    case (state_q)
      IDLE: begin
        // Gated by rst_n so no pop can be requested while reset is held.
        word_read_enable = !word_fifo_empty && rst_n;
      end
      LOAD: begin
        busy = 1'b1;
      end
      SEND: begin
        busy         = 1'b1;
        write_enable = !byte_fifo_full;
`ifdef UNPACKER_PREFETCH_EN
        word_read_enable = last_byte && !byte_fifo_full && !word_fifo_empty;
`else
        word_read_enable = 1'b0;
`endif
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_unpacker.sv
// Randomized and directed bench for unpacker; the expected byte stream is derived from
// the queued words (LSB byte first) and timing from the fetch/emit cycle counts.
module tb_unpacker;
  localparam int DW = 8;
  localparam int WW = 256;
  localparam int NB = WW / DW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [WW-1:0] word_in = '0;
  logic          word_fifo_empty = 1'b1;
  logic          byte_fifo_full = 1'b0;
  logic          word_read_enable;
  logic          write_enable;
  logic          busy;
  logic [DW-1:0] data_out;

  always #5 clk = ~clk;

  unpacker #(.DATA_WIDTH(DW), .WORD_WIDTH(WW)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .word_in          (word_in),
    .word_fifo_empty  (word_fifo_empty),
    .word_read_enable (word_read_enable),
    .byte_fifo_full   (byte_fifo_full),
    .data_out         (data_out),
    .write_enable     (write_enable),
    .busy             (busy)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int nb = 0;
  int mode = 0;
  int stall5 = 0;
  int stall31 = 0;
  bit check_hold = 0;

  logic [WW-1:0] wq[$];
  logic [DW-1:0] exp_q[$];
  int            we_cyc_q[$];
  int            re_cyc_q[$];
  logic          pop_pending = 1'b0;
  logic [WW-1:0] pop_word = '0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference: a word contributes its bytes to the expected stream lowest byte first.
  task automatic push_word(input logic [WW-1:0] w);
    wq.push_back(w);
    for (int k = 0; k < NB; k++) exp_q.push_back(w[k*DW +: DW]);
  endtask

  function automatic logic [WW-1:0] pattern_word(input int kind);
    logic [WW-1:0] w;
    for (int k = 0; k < NB; k++) begin
      case (kind)
        0:       w[k*DW +: DW] = DW'(k);
        1:       w[k*DW +: DW] = 8'hAA;
        2:       w[k*DW +: DW] = 8'h55;
        3:       w[k*DW +: DW] = 8'h33;
        default: w[k*DW +: DW] = DW'($urandom);
      endcase
    end
    return w;
  endfunction

  function automatic logic pick_full();
    if (mode == 1) begin
      if (nb == 5 && stall5 < 3) begin stall5++; return 1'b1; end
      if (nb == 31 && stall31 < 1) begin stall31++; return 1'b1; end
      return 1'b0;
    end
    if (mode == 2) return ($urandom_range(0, 3) == 0);
    return 1'b0;
  endfunction

  task automatic clear_trace();
    nb = 0;
    we_cyc_q.delete();
    re_cyc_q.delete();
  endtask

  // One clock: drive at the falling edge, sample combinational outputs 1 ns later.
  task automatic cycle();
    @(negedge clk);
    cyc++;
    if (pop_pending) begin
      word_in     = pop_word;
      pop_pending = 1'b0;
    end
    byte_fifo_full  = pick_full();
    word_fifo_empty = (wq.size() == 0);
    #1;
    if (check_hold && byte_fifo_full && exp_q.size() > 0)
      check_val("hold", data_out, exp_q[0]);
    if (write_enable) begin
      if (exp_q.size() > 0) check_val("byte", data_out, exp_q.pop_front());
      else check_val("spurious_we", write_enable, 0);
      nb++;
      we_cyc_q.push_back(cyc);
    end
    if (word_read_enable) begin
      if (wq.size() > 0) begin
        pop_word    = wq.pop_front();
        pop_pending = 1'b1;
      end else begin
        check_val("re_on_empty", word_read_enable, 0);
      end
      re_cyc_q.push_back(cyc);
    end
  endtask

  task automatic run_until(input int target, input int budget);
    int b = budget;
    while (nb < target && b > 0) begin
      cycle();
      b--;
    end
    if (nb < target) check_val("timeout", nb, target);
  endtask

  initial begin
    // Reset held, then idle with an empty word FIFO.
    rst_n = 1'b0;
    repeat (3) cycle();
    check_val("reset_outs", {write_enable, word_read_enable, busy, data_out}, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      cycle();
      check_val("idle", {write_enable, word_read_enable, busy, data_out}, 0);
    end

    // Single counting word, no backpressure.
    clear_trace();
    mode = 0;
    push_word(pattern_word(0));
    run_until(NB, 200);
    repeat (3) cycle();
    check_val("one_re_count", re_cyc_q.size(), 1);
    check_val("one_bytes", nb, NB);
    if (we_cyc_q.size() == NB && re_cyc_q.size() >= 1) begin
      check_val("first_latency", we_cyc_q[0] - re_cyc_q[0], 2);
      check_val("one_span", we_cyc_q[NB-1] - we_cyc_q[0] + 1, NB);
    end
    check_val("idle_after", {busy, write_enable}, 0);

    // Same word with stalls at byte 5 (3 cycles) and byte 31 (1 cycle).
    clear_trace();
    mode = 1;
    stall5 = 0;
    stall31 = 0;
    check_hold = 1;
    push_word(pattern_word(0));
    run_until(NB, 200);
    repeat (3) cycle();
    check_hold = 0;
    check_val("stall_bytes", nb, NB);
    if (we_cyc_q.size() == NB) check_val("stall_span", we_cyc_q[NB-1] - we_cyc_q[0] + 1, NB + 4);

    // Two words queued back to back.
    clear_trace();
    mode = 0;
    push_word(pattern_word(1));
    push_word(pattern_word(2));
    run_until(2 * NB, 400);
    repeat (3) cycle();
    check_val("two_re_count", re_cyc_q.size(), 2);
    if (we_cyc_q.size() == 2 * NB && re_cyc_q.size() == 2) begin
`ifdef UNPACKER_PREFETCH_EN
      check_val("two_gap", we_cyc_q[NB] - we_cyc_q[0], NB + 1);
      check_val("prefetch_at_last", re_cyc_q[1], we_cyc_q[NB-1]);
`else
      check_val("two_gap", we_cyc_q[NB] - we_cyc_q[0], NB + 2);
      check_val("fetch_after_last", re_cyc_q[1], we_cyc_q[NB-1] + 1);
`endif
    end

    // Reset mid-word at byte 10, then a fresh word must come out clean.
    clear_trace();
    mode = 0;
    push_word(pattern_word(0));
    run_until(10, 200);
    #2;
    rst_n = 1'b0;
    #1;
    check_val("rst_async", {write_enable, word_read_enable, busy, data_out}, 0);
    exp_q.delete();
    wq.delete();
    pop_pending = 1'b0;
    repeat (2) cycle();
    rst_n = 1'b1;
    clear_trace();
    push_word(pattern_word(3));
    run_until(NB, 200);
    repeat (3) cycle();
    check_val("post_rst_bytes", nb, NB);
    check_val("post_rst_left", exp_q.size(), 0);

    // Random words arriving at random times with random backpressure.
    clear_trace();
    mode = 2;
    begin
      int pushes_left = 6;
      int budget = 5000;
      while ((pushes_left > 0 || nb < 6 * NB) && budget > 0) begin
        if (pushes_left > 0 && $urandom_range(0, 7) == 0) begin
          push_word(pattern_word(4));
          pushes_left--;
        end
        cycle();
        budget--;
      end
      if (nb < 6 * NB) check_val("rand_timeout", nb, 6 * NB);
    end
    mode = 0;
    repeat (4) cycle();
    check_val("rand_bytes", nb, 6 * NB);
    check_val("rand_left", exp_q.size(), 0);
    check_val("rand_re_count", re_cyc_q.size(), 6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
